// File: rtl/aidc_wdata_burst_buffer_if.sv
// ============================================================================
// aidc_wdata_burst_buffer_if
// ----------------------------------------------------------------------------
// Purpose : AXI4 W-channel bundle (valid/ready handshake plus payload) shared
//           by the upstream and downstream sides of the W burst buffer.
// Signals :
//   wvalid  beat valid                    (master -> slave)
//   wready  beat accepted                 (slave  -> master)
//   wdata   beat data, DATA_WIDTH bits    (master -> slave)
//   wstrb   byte strobes, DATA_WIDTH/8    (master -> slave)
//   wlast   last beat of the burst        (master -> slave)
// ============================================================================
interface aidc_wdata_burst_buffer_if #(
   parameter int DATA_WIDTH = 128
);
   logic                      wvalid;
   logic                      wready;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH/8-1:0]   wstrb;
   logic                      wlast;

   // Side that produces beats
   modport master (
      output wvalid,
      output wdata,
      output wstrb,
      output wlast,
      input  wready
   );

   // Side that consumes beats
   modport slave (
      input  wvalid,
      input  wdata,
      input  wstrb,
      input  wlast,
      output wready
   );
endinterface

// File: rtl/aidc_wdata_burst_buffer.sv
// ============================================================================
// aidc_wdata_burst_buffer
// ----------------------------------------------------------------------------
// Purpose : Store-and-forward AXI4 W buffer. A burst is released to the
//           compressor only after its WLAST beat has been stored, so the
//           downstream side sees the beats of a burst back to back. A burst
//           that fills the whole buffer without a WLAST is forwarded in
//           cut-through mode (FWD) and flagged on the sticky err_o.
// Ports   :
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   s_w          upstream W channel (slave modport), wready = count < DEPTH
//   m_w          downstream W channel (master modport), payload = head entry
//   burst_cnt_o  number of complete bursts currently held
//   err_o        sticky: an oversized burst was detected (cleared by reset)
// ============================================================================
module aidc_wdata_burst_buffer #(
   parameter int DATA_WIDTH = 128,
   parameter int DEPTH      = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   aidc_wdata_burst_buffer_if.slave   s_w,
   aidc_wdata_burst_buffer_if.master  m_w,
   output logic [$clog2(DEPTH):0]     burst_cnt_o,
   output logic                       err_o
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int STRB_W  = DATA_WIDTH / 8;
   localparam int ENTRY_W = DATA_WIDTH + STRB_W + 1;

   typedef enum logic {
      ST_STORE = 1'b0,
      ST_FWD   = 1'b1
   } state_e;

   typedef logic [ENTRY_W-1:0] entry_t;

   entry_t              mem_q [DEPTH];

   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q,  count_d;
   logic [CNT_W-1:0]    burst_q,  burst_d;
   state_e              state_q,  state_d;
   logic                valid_q,  valid_d;
   logic                ready_q,  ready_d;
   logic                err_q,    err_d;

   logic                push_s;
   logic                pop_s;
   logic                push_last_s;
   logic                pop_last_s;
   entry_t              head_s;

   // Handshake qualification and head-of-queue decode
   assign push_s      = s_w.wvalid && ready_q;
   assign pop_s       = valid_q && m_w.wready;
   assign head_s      = mem_q[rd_ptr_q];
   assign push_last_s = push_s && s_w.wlast;
   assign pop_last_s  = pop_s && head_s[0];

   assign s_w.wready  = ready_q;
   assign m_w.wvalid  = valid_q;
   assign m_w.wdata   = head_s[ENTRY_W-1 -: DATA_WIDTH];
   assign m_w.wstrb   = head_s[STRB_W:1];
   assign m_w.wlast   = head_s[0];
   assign burst_cnt_o = burst_q;
   assign err_o       = err_q;

   // Beat storage; payload needs no reset since it is only read when valid
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= {s_w.wdata, s_w.wstrb, s_w.wlast};
      end
   end

   // Next-state for pointers, occupancy, burst count, FSM and output flags
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      burst_d  = burst_q;
      state_d  = state_q;
      err_d    = err_q;
      valid_d  = valid_q;
      ready_d  = ready_q;

      // Pointers wrap naturally because DEPTH is a power of two
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      case ({push_last_s, pop_last_s})
         2'b10:   burst_d = burst_q + CNT_W'(1);
         2'b01:   burst_d = burst_q - CNT_W'(1);
         default: burst_d = burst_q;
      endcase

      // The transition is evaluated on next-state occupancy so that FWD and
      // err_o are visible in the cycle right after the filling beat lands.
      // While in STORE with no complete burst nothing can pop, so the full
      // condition is reached only through a push.
      case (state_q)
         ST_STORE: begin
            if ((count_d == CNT_W'(DEPTH)) && (burst_d == {CNT_W{1'b0}})) begin
               state_d = ST_FWD;
            end else begin
               state_d = ST_STORE;
            end
         end
         ST_FWD: begin
            if (pop_last_s) begin
               state_d = ST_STORE;
            end else begin
               state_d = ST_FWD;
            end
         end
         default: state_d = ST_STORE;
      endcase

      if ((state_q == ST_STORE) && (state_d == ST_FWD)) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end

      // Valid is precomputed from next state so the output is a flop; it can
      // only fall after a pop because neither burst_d nor count_d drop
      // without one.
      if (state_d == ST_FWD) begin
         valid_d = (count_d != {CNT_W{1'b0}});
      end else begin
         valid_d = (burst_d != {CNT_W{1'b0}});
      end

      ready_d = (count_d < CNT_W'(DEPTH));
   end

   // Control state registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         burst_q  <= {CNT_W{1'b0}};
         state_q  <= ST_STORE;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         burst_q  <= burst_d;
         state_q  <= state_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
         ready_q  <= ready_d;
      end
   end

endmodule

// File: tb/tb_aidc_wdata_burst_buffer.sv
// ============================================================================
// tb_aidc_wdata_burst_buffer
// ----------------------------------------------------------------------------
// Directed and randomised-length burst traffic into the W burst buffer. The
// driver records every accepted beat in an expected queue; an independent
// monitor pops that queue whenever the DUT hands a beat downstream and also
// tracks the expected number of complete bursts held.
// ============================================================================
module tb_aidc_wdata_burst_buffer;

   localparam int DW    = 128;
   localparam int SW    = DW / 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic          last;
   } beat_t;

   logic          clk;
   logic          rst_n;
   logic [CW-1:0] burst_cnt;
   logic          err;

   aidc_wdata_burst_buffer_if #(.DATA_WIDTH(DW)) s_w ();
   aidc_wdata_burst_buffer_if #(.DATA_WIDTH(DW)) m_w ();

   aidc_wdata_burst_buffer #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_w         (s_w),
      .m_w         (m_w),
      .burst_cnt_o (burst_cnt),
      .err_o       (err)
   );

   beat_t exp_q[$];
   int    n_vec       = 0;
   int    n_miss      = 0;
   int    exp_bursts  = 0;
   bit    rand_ready  = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat until accepted; record it as expected at the accepting edge
   task automatic push_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
      bit done = 1'b0;
      s_w.wvalid = 1'b1;
      s_w.wdata  = d;
      s_w.wstrb  = s;
      s_w.wlast  = l;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (s_w.wready) begin
            exp_q.push_back(beat_t'({d, s, l}));
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      s_w.wvalid = 1'b0;
      n_vec++;
      if (!done) begin
         n_miss++;
         $display("FAIL push_timeout: beat %0h not accepted, expected acceptance within 200 cycles", d);
      end
   endtask

   task automatic drain(input string name, input int budget, output int cycles);
      cycles = 0;
      while (exp_q.size() != 0 && cycles < budget) begin
         tick();
         cycles++;
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL %s: %0d beats still outstanding, expected 0 within %0d cycles",
                  name, exp_q.size(), budget);
      end
   endtask

   // Monitor: burst-count model and ordered data/strobe/last scoreboard
   initial begin
      forever begin
         beat_t e;
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            exp_bursts = 0;
         end
         check("burst_cnt", DW'(burst_cnt), DW'(exp_bursts));
         if (rst_n) begin
            if (s_w.wvalid && s_w.wready && s_w.wlast) exp_bursts++;
            if (m_w.wvalid && m_w.wready) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_miss++;
                  $display("FAIL unexpected_beat: got data %0h, expected no beat", m_w.wdata);
               end else begin
                  e = exp_q.pop_front();
                  check("m_wdata", m_w.wdata, e.data);
                  check("m_wstrb", DW'(m_w.wstrb), DW'(e.strb));
                  check("m_wlast", DW'(m_w.wlast), DW'(e.last));
                  if (e.last) exp_bursts--;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      logic [DW-1:0] base;
      s_w.wvalid = 1'b0;
      s_w.wdata  = {DW{1'b0}};
      s_w.wstrb  = {SW{1'b0}};
      s_w.wlast  = 1'b0;
      m_w.wready = 1'b0;
      rst_n      = 1'b1;
      #1 rst_n   = 1'b0;
      #2;
      check("rst_m_wvalid", DW'(m_w.wvalid), DW'(1'b0));
      check("rst_s_wready", DW'(s_w.wready), DW'(1'b1));
      check("rst_burst",    DW'(burst_cnt),  DW'(0));
      check("rst_err",      DW'(err),        DW'(1'b0));
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Single 4-beat burst, downstream always ready
      m_w.wready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         push_beat(DW'(i), 16'hFFFF, (i == 4));
         if (i < 4) check("single_hold_valid", DW'(m_w.wvalid), DW'(1'b0));
      end
      check("single_valid_after_last", DW'(m_w.wvalid), DW'(1'b1));
      check("single_burst_one", DW'(burst_cnt), DW'(1));
      drain("single_drain", 50, cyc);
      check("single_drain_cycles", DW'(cyc), DW'(4));
      check("single_idle_valid", DW'(m_w.wvalid), DW'(1'b0));

      // Three back-to-back bursts under 20 cycles of backpressure
      m_w.wready = 1'b0;
      for (int i = 0; i < 12; i++) push_beat(DW'(16'h0010 + i), SW'(16'h0F00 + i), (i % 4 == 3));
      repeat (8) tick();
      check("bp_burst_three", DW'(burst_cnt), DW'(3));
      check("bp_s_wready", DW'(s_w.wready), DW'(1'b1));
      m_w.wready = 1'b1;
      drain("bp_drain", 50, cyc);
      check("bp_drain_cycles", DW'(cyc), DW'(12));

      // Fill to DEPTH, then push while draining
      m_w.wready = 1'b0;
      for (int i = 0; i < 16; i++) push_beat(DW'(16'h0030 + i), SW'(i), (i % 4 == 3));
      check("fill_s_wready_low", DW'(s_w.wready), DW'(1'b0));
      check("fill_burst_four", DW'(burst_cnt), DW'(4));
      m_w.wready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_beat(DW'(16'h0050 + i), 16'hA5A5, (i == 3));
         check("fill_sim_s_wready", DW'(s_w.wready), DW'(1'b1));
      end
      drain("fill_drain", 60, cyc);

      // Oversized 20-beat burst
      m_w.wready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         push_beat(DW'(16'h0100 + i), SW'(16'h1 << i), 1'b0);
         if (i == 14) begin
            check("over_err_before", DW'(err), DW'(1'b0));
            check("over_valid_before", DW'(m_w.wvalid), DW'(1'b0));
         end
      end
      check("over_err_set", DW'(err), DW'(1'b1));
      check("over_fwd_valid", DW'(m_w.wvalid), DW'(1'b1));
      check("over_s_wready_low", DW'(s_w.wready), DW'(1'b0));
      m_w.wready = 1'b1;
      for (int i = 16; i < 20; i++) push_beat(DW'(16'h0100 + i), 16'h0000, (i == 19));
      drain("over_drain", 60, cyc);
      check("over_err_sticky", DW'(err), DW'(1'b1));
      check("over_idle_valid", DW'(m_w.wvalid), DW'(1'b0));
      // Back in STORE: a partial burst must be held back
      push_beat(DW'(16'h0200), 16'h00FF, 1'b0);
      repeat (3) tick();
      check("store_partial_held", DW'(m_w.wvalid), DW'(1'b0));
      push_beat(DW'(16'h0201), 16'hFF00, 1'b1);
      drain("store_drain", 20, cyc);

      // Asynchronous reset with one full and one partial burst buffered
      m_w.wready = 1'b0;
      for (int i = 0; i < 4; i++) push_beat(DW'(16'h0300 + i), 16'hFFFF, (i == 3));
      push_beat(DW'(16'h0310), 16'hFFFF, 1'b0);
      push_beat(DW'(16'h0311), 16'hFFFF, 1'b0);
      check("pre_rst_valid", DW'(m_w.wvalid), DW'(1'b1));
      check("pre_rst_burst", DW'(burst_cnt), DW'(1));
      rst_n = 1'b0;
      #1;
      check("mid_rst_m_wvalid", DW'(m_w.wvalid), DW'(1'b0));
      check("mid_rst_s_wready", DW'(s_w.wready), DW'(1'b1));
      check("mid_rst_burst",    DW'(burst_cnt),  DW'(0));
      check("mid_rst_err",      DW'(err),        DW'(1'b0));
      tick();
      rst_n = 1'b1;
      tick();
      m_w.wready = 1'b1;
      for (int i = 0; i < 4; i++) push_beat(DW'(16'h0320 + i), 16'h3C3C, (i == 3));
      drain("post_rst_drain", 20, cyc);
      check("post_rst_idle_valid", DW'(m_w.wvalid), DW'(1'b0));

      // 40 random-length bursts with random downstream readiness
      rand_ready = 1'b1;
      fork
         begin
            while (rand_ready) begin
               @(posedge clk);
               #1;
               if (rand_ready) m_w.wready = 1'($urandom_range(0, 1));
            end
         end
      join_none
      for (int b = 0; b < 40; b++) begin
         int len;
         len = int'($urandom_range(1, 8));
         for (int k = 0; k < len; k++) begin
            base = {$urandom(), $urandom(), $urandom(), $urandom()};
            push_beat(base, SW'($urandom_range(0, 65535)), (k == len - 1));
         end
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #2;
      m_w.wready = 1'b1;
      drain("wrap_drain", 400, cyc);
      check("final_burst_zero", DW'(burst_cnt), DW'(0));
      check("final_valid_low", DW'(m_w.wvalid), DW'(1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
